// File: rtl/controller_sequencer.sv
// SAP-1 control unit: a six-state one-hot ring (T1-T3 fetch, T4-T6 execute) decoding the IR opcode into datapath strobes.
// Strobes are combinational from the registered ring and halt flag; run=0 freezes the ring and blanks all strobes.
module controller_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [3:0] opcode,
   output logic       pc_increment,
   output logic       pc_enable,
   output logic       mar_load,
   output logic       ram_enable,
   output logic       ir_load,
   output logic       ir_enable,
   output logic       a_load,
   output logic       a_enable,
   output logic       b_load,
   output logic       alu_enable,
   output logic       alu_subtract,
   output logic       out_load,
   output logic [5:0] t_state,
   output logic       halted
);

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } ring_e;

   typedef struct packed {
      logic pc_increment;
      logic pc_enable;
      logic mar_load;
      logic ram_enable;
      logic ir_load;
      logic ir_enable;
      logic a_load;
      logic a_enable;
      logic b_load;
      logic alu_enable;
      logic alu_subtract;
      logic out_load;
   } ctrl_t;

   ring_e state_q, state_d;
   logic  halted_q, halted_d;
   logic  advance;
   ctrl_t ctrl;

   assign advance = run & ~halted_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= T1;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      case (state_q)
         T1: if (advance) state_d = T2;
         T2: if (advance) state_d = T3;
         T3: if (advance) state_d = T4;
         // HLT parks the ring on T4 instead of advancing
         T4: if (advance) begin
            if (opcode == OP_HLT) halted_d = 1'b1;
            else                  state_d  = T5;
         end
         T5: if (advance) state_d = T6;
         T6: if (advance) state_d = T1;
         default: state_d = T1;
      endcase
   end

   always_comb begin
      ctrl = '0;
      if (!reset && advance) begin
         case (state_q)
            T1: begin
               ctrl.pc_enable = 1'b1;
               ctrl.mar_load  = 1'b1;
            end
            T2: ctrl.pc_increment = 1'b1;
            T3: begin
               ctrl.ram_enable = 1'b1;
               ctrl.ir_load    = 1'b1;
            end
            T4: begin
               if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                  ctrl.ir_enable = 1'b1;
                  ctrl.mar_load  = 1'b1;
               end else if (opcode == OP_OUT) begin
                  ctrl.a_enable = 1'b1;
                  ctrl.out_load = 1'b1;
               end
            end
            T5: begin
               if (opcode == OP_LDA) begin
                  ctrl.ram_enable = 1'b1;
                  ctrl.a_load     = 1'b1;
               end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                  ctrl.ram_enable = 1'b1;
                  ctrl.b_load     = 1'b1;
               end
            end
            T6: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  ctrl.alu_enable   = 1'b1;
                  ctrl.a_load       = 1'b1;
                  ctrl.alu_subtract = (opcode == OP_SUB);
               end
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign pc_increment = ctrl.pc_increment;
   assign pc_enable    = ctrl.pc_enable;
   assign mar_load     = ctrl.mar_load;
   assign ram_enable   = ctrl.ram_enable;
   assign ir_load      = ctrl.ir_load;
   assign ir_enable    = ctrl.ir_enable;
   assign a_load       = ctrl.a_load;
   assign a_enable     = ctrl.a_enable;
   assign b_load       = ctrl.b_load;
   assign alu_enable   = ctrl.alu_enable;
   assign alu_subtract = ctrl.alu_subtract;
   assign out_load     = ctrl.out_load;
   assign t_state      = state_q;
   assign halted       = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: directed test-plan scenarios followed by random instruction streams,
// with expectations queued by the driver and compared by an independent negedge monitor.
module tb_controller_sequencer;

   logic       clk;
   logic       reset;
   logic       run;
   logic [3:0] opcode;
   logic       pc_increment, pc_enable, mar_load, ram_enable, ir_load, ir_enable;
   logic       a_load, a_enable, b_load, alu_enable, alu_subtract, out_load;
   logic [5:0] t_state;
   logic       halted;

   controller_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .opcode       (opcode),
      .pc_increment (pc_increment),
      .pc_enable    (pc_enable),
      .mar_load     (mar_load),
      .ram_enable   (ram_enable),
      .ir_load      (ir_load),
      .ir_enable    (ir_enable),
      .a_load       (a_load),
      .a_enable     (a_enable),
      .b_load       (b_load),
      .alu_enable   (alu_enable),
      .alu_subtract (alu_subtract),
      .out_load     (out_load),
      .t_state      (t_state),
      .halted       (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe bit positions, ordered as the monitor packs them.
   localparam logic [11:0] M_PC_INC = 12'b1000_0000_0000;
   localparam logic [11:0] M_PC_EN  = 12'b0100_0000_0000;
   localparam logic [11:0] M_MAR    = 12'b0010_0000_0000;
   localparam logic [11:0] M_RAM    = 12'b0001_0000_0000;
   localparam logic [11:0] M_IR_LD  = 12'b0000_1000_0000;
   localparam logic [11:0] M_IR_EN  = 12'b0000_0100_0000;
   localparam logic [11:0] M_A_LD   = 12'b0000_0010_0000;
   localparam logic [11:0] M_A_EN   = 12'b0000_0001_0000;
   localparam logic [11:0] M_B_LD   = 12'b0000_0000_1000;
   localparam logic [11:0] M_ALU    = 12'b0000_0000_0100;
   localparam logic [11:0] M_SUB    = 12'b0000_0000_0010;
   localparam logic [11:0] M_OUT    = 12'b0000_0000_0001;

   int          checks = 0;
   int          errors = 0;
   logic [18:0] sb[$];
   string       tag_q[$];

   // Reference model: step number 1..6 and halt flag.
   int m_step   = 1;
   bit m_halted = 1'b0;

   function automatic logic [11:0] expect_strobes(input int step, input logic [3:0] op);
      logic [11:0] s;
      s = '0;
      if (step == 1) s = M_PC_EN | M_MAR;
      if (step == 2) s = M_PC_INC;
      if (step == 3) s = M_RAM | M_IR_LD;
      if (step >= 4) begin
         case (op)
            4'b0000: s = (step == 4) ? (M_IR_EN | M_MAR) : (step == 5) ? (M_RAM | M_A_LD) : '0;
            4'b0001: s = (step == 4) ? (M_IR_EN | M_MAR) : (step == 5) ? (M_RAM | M_B_LD) : (M_ALU | M_A_LD);
            4'b0010: s = (step == 4) ? (M_IR_EN | M_MAR) : (step == 5) ? (M_RAM | M_B_LD) : (M_ALU | M_A_LD | M_SUB);
            4'b1110: s = (step == 4) ? (M_A_EN | M_OUT) : '0;
            default: s = '0;
         endcase
      end
      return s;
   endfunction

   // Drive one cycle, queue its expected outputs, then advance the model past the edge.
   task automatic tick(input logic r, input logic rn, input logic [3:0] op, input bit chk, input string tag);
      logic [11:0] s;
      reset  = r;
      run    = rn;
      opcode = op;
      s = (r || !rn || m_halted) ? 12'h000 : expect_strobes(m_step, op);
      if (chk) begin
         sb.push_back({s, 6'(1 << (m_step - 1)), m_halted});
         tag_q.push_back(tag);
      end
      @(posedge clk);
      #1;
      if (r) begin
         m_step   = 1;
         m_halted = 1'b0;
      end else if (rn && !m_halted) begin
         if (m_step == 4 && op == 4'hF) m_halted = 1'b1;
         else                           m_step   = (m_step == 6) ? 1 : m_step + 1;
      end
   endtask

   // One instruction from T1; garbage opcode in fetch, optional pause or reset at a given step.
   task automatic instr(input logic [3:0] op, input int pause_at, input int pause_n,
                        input int rst_at, input string tag);
      logic [3:0] o;
      for (int s = 1; s <= 6; s++) begin
         o = (s >= 4) ? op : 4'($urandom);
         if (s == pause_at) begin
            for (int k = 0; k < pause_n; k++) tick(1'b0, 1'b0, o, 1'b1, tag);
         end
         if (s == rst_at) begin
            tick(1'b1, 1'($urandom), o, 1'b1, tag);
            return;
         end
         tick(1'b0, 1'b1, o, 1'b1, tag);
         if (m_halted) return;
      end
   endtask

   always @(negedge clk) begin
      logic [18:0] e;
      logic [18:0] a;
      string       tg;
      if (sb.size() > 0) begin
         e  = sb.pop_front();
         tg = tag_q.pop_front();
         a  = {pc_increment, pc_enable, mar_load, ram_enable, ir_load, ir_enable,
               a_load, a_enable, b_load, alu_enable, alu_subtract, out_load, t_state, halted};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: strobes/t_state/halted got %b_%b_%b want %b_%b_%b", tg,
                     a[18:7], a[6:1], a[0], e[18:7], e[6:1], e[0]);
         end
         checks++;
         bus_onehot: assert ($countones({pc_enable, ram_enable, ir_enable, a_enable, alu_enable}) <= 1)
         else begin
            errors++;
            $display("FAIL bus_drivers %s: got %b want at most one set", tg,
                     {pc_enable, ram_enable, ir_enable, a_enable, alu_enable});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] op;
      int         pick;
      reset  = 1'b1;
      run    = 1'b1;
      opcode = 4'h0;
      @(posedge clk);
      #1;
      // Reset held two cycles; the first only clears power-up X.
      tick(1'b1, 1'b1, 4'h0, 1'b0, "reset0");
      tick(1'b1, 1'b1, 4'h0, 1'b1, "reset1");
      // LDA, ADD, SUB, OUT, NOP each run a full six cycles.
      instr(4'b0000, 0, 0, 0, "lda");
      instr(4'b0001, 0, 0, 0, "add");
      instr(4'b0010, 0, 0, 0, "sub");
      instr(4'b1110, 0, 0, 0, "out");
      instr(4'b0101, 0, 0, 0, "nop");
      // ADD paused three cycles at T5.
      instr(4'b0001, 5, 3, 0, "add_pause");
      // SUB reset during T5.
      instr(4'b0010, 0, 0, 5, "sub_reset");
      instr(4'b0000, 0, 0, 0, "lda_after_rst");
      // HLT with run dropped at T4 first, then held halted 20 cycles.
      instr(4'b1111, 4, 2, 0, "hlt");
      for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 4'hF, 1'b1, "halted");
      tick(1'b1, 1'b1, 4'hF, 1'b1, "hlt_reset");
      instr(4'b0001, 0, 0, 0, "add_after_hlt");

      for (int n = 0; n < 60; n++) begin
         pick = $urandom_range(0, 6);
         case (pick)
            0: op = 4'b0000;
            1: op = 4'b0001;
            2: op = 4'b0010;
            3: op = 4'b1110;
            4: op = 4'b1111;
            default: op = 4'($urandom);
         endcase
         instr(op,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
               $urandom_range(1, 4),
               ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0,
               "random");
         if (m_halted) begin
            for (int k = 0; k < 4; k++) tick(1'b0, 1'($urandom), 4'($urandom), 1'b1, "random_halted");
            tick(1'b1, 1'($urandom), 4'($urandom), 1'b1, "random_hlt_reset");
         end
      end

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 control unit. A six-state ring counter steps T1..T6 per instruction: T1–T3 fetch, T4–T6 execute. The unit decodes the 4-bit opcode held in the instruction register and drives the load/enable/increment strobes of the PC, MAR, RAM, IR, A register, ALU, B register and output register, which all share the 8-bit w_bus. All strobes are active-high, to match the datapath registers.

## Interface
- No parameters. Opcode encoding is fixed: LDA 0000, ADD 0001, SUB 0010, OUT 1110, HLT 1111.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high. Sampled on the rising edge of clk.
- run  in  1  1 = sequencer advances; 0 = pause (state frozen, all strobes 0).
- opcode  in  4  upper nibble of the IR. Valid from T4 onward.
- pc_increment  out  1  PC += 1 at the next edge.
- pc_enable  out  1  PC drives w_bus.
- mar_load  out  1  MAR loads from w_bus.
- ram_enable  out  1  RAM[MAR] drives w_bus.
- ir_load  out  1  IR loads from w_bus.
- ir_enable  out  1  IR operand nibble drives w_bus.
- a_load  out  1  A register loads from w_bus.
- a_enable  out  1  A register drives w_bus.
- b_load  out  1  B register loads from w_bus.
- alu_enable  out  1  ALU result drives w_bus.
- alu_subtract  out  1  ALU computes A−B; 0 selects A+B.
- out_load  out  1  output register loads from w_bus.
- t_state  out  6  one-hot ring state; bit0 = T1 … bit5 = T6.
- halted  out  1  sticky halt flag.

## Operation
- **Registered state:** t_state and halted only. All strobes are combinational from t_state, opcode, run, halted and reset.
- **Strobe forcing:** every strobe is 0 whenever any of these holds:
  - reset = 1
  - run = 0
  - halted = 1
- **Fetch (opcode ignored):**
  - T1: pc_enable, mar_load.
  - T2: pc_increment.
  - T3: ram_enable, ir_load.
- **LDA:**
  - T4: ir_enable, mar_load.
  - T5: ram_enable, a_load.
  - T6: none.
- **ADD:**
  - T4: ir_enable, mar_load.
  - T5: ram_enable, b_load.
  - T6: alu_enable, a_load; alu_subtract = 0.
- **SUB:** same as ADD, except T6 also asserts alu_subtract = 1.
- **OUT:**
  - T4: a_enable, out_load.
  - T5, T6: none.
- **HLT:**
  - T4: no strobes.
  - At the T4 edge: halted <= 1 and the ring freezes at T4 (001000).
- **Any other opcode:** NOP; T4–T6 assert nothing.
- **Bus invariant:** at most one of pc_enable, ram_enable, ir_enable, a_enable, alu_enable is 1 in any cycle. This is an assertion in the bench.
- **t_state invariant:** always exactly one-hot.
- **Illegal state:** a non-one-hot t_state (e.g. from X) is forced to T1 at the next edge.

## Timing
- **Reset:** the edge that samples reset = 1 sets t_state = 000001 and halted = 0. Strobes are 0 while reset is high.
- **After reset:** in the first cycle after reset falls, the T1 strobes are active.
- **Reset priority:** reset overrides run, halted and any mid-instruction state. Reset during T5 gives T1 on the next cycle.
- **Advance:** on each rising edge with run = 1, halted = 0 and reset = 0, the ring rotates T1→T2→…→T6→T1.
- **Cycle count:** every instruction takes exactly 6 cycles, including NOP/OUT idle states. HLT is the exception: it stops at T4.
- **Strobe timing:** strobes are valid for the whole state cycle. Datapath registers capture at the edge that ends that state.
- **IR/opcode handoff:** the IR loads at the end of T3, so opcode is stable for T4–T6. opcode is don't-care in T1–T3.
- **Pause:** run = 0 freezes t_state with no limit on duration. When run returns to 1, the same state's strobes reassert for one full cycle before advancing. No strobe is ever asserted for a partial state.
- **Halt:** halted is registered and rises one cycle after the HLT T4 cycle. It stays at 1 until reset, regardless of run.
- **run vs. HLT:** if run = 0 during HLT T4, the halt is not taken until run = 1 at that edge.

## Test plan
- **Reset:** hold reset 2 cycles with run = 1 -> t_state = 000001, halted = 0, all strobes 0. The cycle after release shows pc_enable = mar_load = 1 and nothing else.
- **LDA:** opcode 0000, run = 1 for 7 cycles -> t_state steps 000001→…→100000→000001, with strobes exactly per the LDA schedule. T6 has no strobes.
- **ADD vs. SUB:**
  - opcode 0001: T5 ram_enable = b_load = 1; T6 alu_enable = a_load = 1, alu_subtract = 0.
  - Repeat with 0010: T6 alu_subtract = 1.
- **Pause:** during ADD, drop run at T5 for 3 cycles -> t_state holds 010000 and all strobes are 0. Raise run -> ram_enable = b_load = 1 for one cycle, then T6.
- **HLT:** opcode 1111 -> T4 strobes 0; halted = 1 next cycle; t_state frozen at 001000 and strobes 0 for 20 cycles with run = 1. Then one reset cycle -> halted = 0, t_state = 000001.
- **NOP and reset:**
  - opcode 0101 -> T4–T6 with no strobes, returns to T1.
  - Assert reset during T5 of SUB -> t_state = 000001 next cycle with no T6 strobes.
  - The bus-invariant assertion never fires in any scenario.
